scan_chain_master: RTL

- Single-clock master that drives a user design through a serial scan chain: the transmit end of the scan interface that the design's scan receiver (clk_scan / scan_en / load_gold style inputs) consumes.
- Accepts a parallel input word, captures the design's current outputs into the chain, and shifts the new word in MSB first while shifting the captured word out.
- Pulses a latch strobe so the design applies the new inputs, then returns the captured word on a valid/ready port.
- Sits between the bench or host-side logic and the scan-chain pins.

---
 rtl/scan_chain_master.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/scan_chain_master.sv
// scan_chain_master
// Drives a user design through a serial scan chain. A parallel word accepted
// on the input port is shifted into the chain MSB first while the word the
// chain captured from the design outputs is shifted out. A latch strobe then
// makes the design apply the new word, and the captured word is returned on
// the output port.
//
// Ports
//   clk, rst              system clock, synchronous active-high reset
//   in_data/valid/ready   word to shift in (ready while idle)
//   out_data/valid/ready  captured word returned to the host
//   scan_clk              generated scan clock, 2*CLK_DIV clk cycles per pulse
//   scan_select           high during the capture pulse
//   scan_data_out         serial data towards the chain
//   scan_data_in          serial data from the chain end
//   scan_latch_en         strobe, design applies the shifted-in word
//
// state   | meaning
// IDLE    | waiting for an input word, in_ready high
// CAPTURE | one scan pulse with scan_select high, chain loads design outputs
// SHIFT   | WIDTH scan pulses, word in and captured word out
// LATCH   | scan_latch_en high for one pulse period, scan_clk held low
// DONE    | out_valid high until out_ready
module scan_chain_master #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             scan_clk,
  output logic             scan_select,
  output logic             scan_data_out,
  input  logic             scan_data_in,
  output logic             scan_latch_en
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, CAPTURE, SHIFT, LATCH, DONE} state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             phase_q, phase_d;   // 0 = low half, 1 = high half
  logic             sample_q, sample_d;
  logic             in_ready_d, out_valid_d, scan_clk_d, scan_select_d;
  logic             scan_data_out_d, scan_latch_en_d;
  logic [WIDTH-1:0] out_data_d;
  logic             half_end;

  assign half_end = (div_cnt_q == DW'(CLK_DIV - 1));

  always_comb begin
    state_d         = state_q;
    div_cnt_d       = '0;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    phase_d         = phase_q;
    sample_d        = sample_q;
    in_ready_d      = in_ready;
    out_valid_d     = out_valid;
    out_data_d      = out_data;
    scan_clk_d      = scan_clk;
    scan_select_d   = scan_select;
    scan_data_out_d = scan_data_out;
    scan_latch_en_d = scan_latch_en;

    // div_cnt free-runs through each half-period while a transfer is active
    if (state_q == CAPTURE || state_q == SHIFT || state_q == LATCH) begin
      div_cnt_d = half_end ? '0 : div_cnt_q + DW'(1);
    end

    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready) begin
          shift_d       = in_data;
          in_ready_d    = 1'b0;
          scan_select_d = 1'b1;
          scan_clk_d    = 1'b0;
          phase_d       = 1'b0;
          state_d       = CAPTURE;
        end
      end
      CAPTURE: begin
        if (half_end) begin
          if (!phase_q) begin
            phase_d    = 1'b1;
            scan_clk_d = 1'b1;
          end else begin
            phase_d         = 1'b0;
            scan_clk_d      = 1'b0;
            scan_select_d   = 1'b0;
            bit_cnt_d       = '0;
            scan_data_out_d = shift_q[WIDTH-1];
            state_d         = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (half_end) begin
          if (!phase_q) begin
            // sample before the chain reacts to the rising scan_clk
            phase_d    = 1'b1;
            scan_clk_d = 1'b1;
            sample_d   = scan_data_in;
          end else begin
            phase_d         = 1'b0;
            scan_clk_d      = 1'b0;
            shift_d         = {shift_q[WIDTH-2:0], sample_q};
            scan_data_out_d = shift_q[WIDTH-2];
            bit_cnt_d       = bit_cnt_q + BW'(1);
            if (bit_cnt_q == BW'(WIDTH - 1)) begin
              scan_data_out_d = 1'b0;
              scan_latch_en_d = 1'b1;
              state_d         = LATCH;
            end
          end
        end
      end
      LATCH: begin
        if (half_end) begin
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d         = 1'b0;
            scan_latch_en_d = 1'b0;
            out_valid_d     = 1'b1;
            out_data_d      = shift_q;
            state_d         = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      div_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      phase_q       <= 1'b0;
      sample_q      <= 1'b0;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_data      <= '0;
      scan_clk      <= 1'b0;
      scan_select   <= 1'b0;
      scan_data_out <= 1'b0;
      scan_latch_en <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      phase_q       <= phase_d;
      sample_q      <= sample_d;
      in_ready      <= in_ready_d;
      out_valid     <= out_valid_d;
      out_data      <= out_data_d;
      scan_clk      <= scan_clk_d;
      scan_select   <= scan_select_d;
      scan_data_out <= scan_data_out_d;
      scan_latch_en <= scan_latch_en_d;
    end
  end

endmodule
